// File: rtl/y86_pkg.sv
// Shared definitions for the SEQ Y86-64 sequencer: instruction codes,
// status codes, the sequencer state encoding and a decode helper.
package y86_pkg;

    // Instruction codes (icode field of the first instruction byte)
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Processor status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_PCUPD     = 3'd6,
        ST_HALT      = 3'd7
    } state_t;

    // Instructions that touch data memory and therefore wait on mem_ready
    function automatic logic needs_mem(input logic [3:0] icode);
        case (icode)
            IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: needs_mem = 1'b1;
            default:                                      needs_mem = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_cond_eval.sv
// Branch / conditional-move condition evaluator. Purely combinational:
// maps the function code and the ZF/SF/OF flags to the jXX/cmovXX outcome.
module y86_cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    output logic       cond
);

    logic lt;

    assign lt = sf ^ of;

    // Decode the condition selected by ifun; undefined codes never take
    always_comb begin
        cond = 1'b0;
        case (ifun)
            4'h0:    cond = 1'b1;          // unconditional
            4'h1:    cond = lt | zf;       // le
            4'h2:    cond = lt;            // l
            4'h3:    cond = zf;            // e
            4'h4:    cond = ~zf;           // ne
            4'h5:    cond = ~lt;           // ge
            4'h6:    cond = ~lt & ~zf;     // g
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle SEQ Y86-64 sequencer. Walks each instruction through
// fetch/decode/execute/memory/write-back/PC-update with one-hot stage
// strobes, owns the condition-code register, registers the jXX/cmovXX
// condition and tracks processor status and retired-instruction count.
//
// Handshakes: instr_valid (fetch) and mem_ready (data memory) are
// completion indications sampled on the rising clock edge while the
// sequencer sits in FETCH or MEMORY respectively; the stage advances on
// the first edge where the signal is high, and the companion inputs
// (icode/ifun/imem_error, dmem_error) are only looked at on that edge.
module seq_stage_controller
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        instr_valid,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic        imem_error,
    input  logic        mem_ready,
    input  logic        dmem_error,
    input  logic        alu_zf,
    input  logic        alu_sf,
    input  logic        alu_of,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        exec_en,
    output logic        mem_en,
    output logic        wb_en,
    output logic        pc_en,
    output logic        cc_zf,
    output logic        cc_sf,
    output logic        cc_of,
    output logic        cnd,
    output logic [2:0]  stat,
    output logic        halted,
    output logic [31:0] retired,
    output state_t      dbg_state
);

    state_t      state;
    state_t      state_n;
    logic [2:0]  stat_n;
    logic [3:0]  icode_q;
    logic [3:0]  ifun_q;
    logic        cond;
    logic        cond_used;

    assign dbg_state = state;

    // Condition from the CC as it stood before this instruction's execute
    y86_cond_eval u_cond_eval (
        .ifun (ifun_q),
        .zf   (cc_zf),
        .sf   (cc_sf),
        .of   (cc_of),
        .cond (cond)
    );

    // Only cmovXX and jXX consume the condition; everything else reports 0
    assign cond_used = ((icode_q == IRRMOVQ) || (icode_q == IJXX)) ? cond : 1'b0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-status selection
    always_comb begin
        state_n = state;
        stat_n  = stat;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (instr_valid) begin
                    if (imem_error) begin
                        state_n = ST_HALT;
                        stat_n  = STAT_ADR;
                    end else if (icode > IPOPQ) begin
                        state_n = ST_HALT;
                        stat_n  = STAT_INS;
                    end else if (icode == IHALT) begin
                        state_n = ST_HALT;
                        stat_n  = STAT_HLT;
                    end else begin
                        state_n = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                state_n = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_n = ST_MEMORY;
            end
            ST_MEMORY: begin
                if (needs_mem(icode_q)) begin
                    if (mem_ready) begin
                        if (dmem_error) begin
                            state_n = ST_HALT;
                            stat_n  = STAT_ADR;
                        end else begin
                            state_n = ST_WRITEBACK;
                        end
                    end
                end else begin
                    state_n = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                state_n = ST_PCUPD;
            end
            ST_PCUPD: begin
                state_n = ST_FETCH;
            end
            ST_HALT: begin
                state_n = ST_HALT;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Stage strobes and halted flag decoded straight from the state
    always_comb begin
        fetch_en  = 1'b0;
        decode_en = 1'b0;
        exec_en   = 1'b0;
        mem_en    = 1'b0;
        wb_en     = 1'b0;
        pc_en     = 1'b0;
        halted    = 1'b0;
        case (state)
            ST_FETCH:     fetch_en  = 1'b1;
            ST_DECODE:    decode_en = 1'b1;
            ST_EXECUTE:   exec_en   = 1'b1;
            ST_MEMORY:    mem_en    = 1'b1;
            ST_WRITEBACK: wb_en     = 1'b1;
            ST_PCUPD:     pc_en     = 1'b1;
            ST_HALT:      halted    = 1'b1;
            default:      ;
        endcase
    end

    // Latch the instruction codes on the accepting fetch edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icode_q <= INOP;
            ifun_q  <= 4'h0;
        end else if ((state == ST_FETCH) && instr_valid) begin
            icode_q <= icode;
            ifun_q  <= ifun;
        end
    end

    // Condition-code register and registered condition, updated leaving EXECUTE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_zf <= 1'b1;
            cc_sf <= 1'b0;
            cc_of <= 1'b0;
            cnd   <= 1'b0;
        end else if (state == ST_EXECUTE) begin
            cnd <= cond_used;
            if (icode_q == IOPQ) begin
                cc_zf <= alu_zf;
                cc_sf <= alu_sf;
                cc_of <= alu_of;
            end
        end
    end

    // Processor status register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat <= STAT_AOK;
        end else begin
            stat <= stat_n;
        end
    end

    // Retired-instruction counter, bumped as PC update completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= 32'd0;
        end else if (state == ST_PCUPD) begin
            retired <= retired + 32'd1;
        end
    end

endmodule

// File: tb/tb_seq_stage_controller.sv
// Directed testbench for seq_stage_controller.
module tb_seq_stage_controller;
    import y86_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start, instr_valid, imem_error, mem_ready, dmem_error;
    logic [3:0]  icode, ifun;
    logic        alu_zf, alu_sf, alu_of;
    logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en;
    logic        cc_zf, cc_sf, cc_of, cnd, halted;
    logic [2:0]  stat;
    logic [31:0] retired;
    state_t      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    seq_stage_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instr_valid (instr_valid),
        .icode       (icode),
        .ifun        (ifun),
        .imem_error  (imem_error),
        .mem_ready   (mem_ready),
        .dmem_error  (dmem_error),
        .alu_zf      (alu_zf),
        .alu_sf      (alu_sf),
        .alu_of      (alu_of),
        .fetch_en    (fetch_en),
        .decode_en   (decode_en),
        .exec_en     (exec_en),
        .mem_en      (mem_en),
        .wb_en       (wb_en),
        .pc_en       (pc_en),
        .cc_zf       (cc_zf),
        .cc_sf       (cc_sf),
        .cc_of       (cc_of),
        .cnd         (cnd),
        .stat        (stat),
        .halted      (halted),
        .retired     (retired),
        .dbg_state   (dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start       = 1'b0;
        instr_valid = 1'b0;
        icode       = INOP;
        ifun        = 4'h0;
        imem_error  = 1'b0;
        mem_ready   = 1'b0;
        dmem_error  = 1'b0;
        alu_zf      = 1'b0;
        alu_sf      = 1'b0;
        alu_of      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #13;
        tick();
        rst_n = 1'b1;
    endtask

    // Pulse start for one edge; afterwards the sequencer is in FETCH
    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 000000",
                     {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en});
        end
        n_checks++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_cc: got %b expected 100", {cc_zf, cc_sf, cc_of});
        end
        n_checks++;
        if ({cnd, halted, stat} !== 5'b00001 || retired !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_status: cnd=%b halted=%b stat=%0d retired=%0d expected 0 0 1 0",
                     cnd, halted, stat, retired);
        end
        tick();
        rst_n = 1'b1;
        // start low: IDLE must persist
        tick();
        n_checks++;
        if (dbg_state !== ST_IDLE || fetch_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: state=%0d fetch_en=%b expected 0 0", dbg_state, fetch_en);
        end
    endtask

    // irmovq with alu_zf=0: CC must keep its reset value
    task automatic test_irmovq();
        go();
        n_checks++;
        if (fetch_en !== 1'b1) begin
            n_fail++;
            $display("FAIL irmovq_fetch: fetch_en=%b expected 1", fetch_en);
        end
        instr_valid = 1'b1; icode = IIRMOVQ; ifun = 4'h0;
        alu_zf = 1'b0; alu_sf = 1'b1; alu_of = 1'b1;
        tick();
        instr_valid = 1'b0;
        n_checks++;
        if ({fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en} !== 6'b010000) begin
            n_fail++;
            $display("FAIL irmovq_decode: strobes=%b expected 010000",
                     {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en});
        end
        tick(); tick(); tick(); tick();
        n_checks++;
        if (pc_en !== 1'b1 || retired !== 32'd0) begin
            n_fail++;
            $display("FAIL irmovq_pcupd: pc_en=%b retired=%0d expected 1 0", pc_en, retired);
        end
        tick();
        n_checks++;
        if (fetch_en !== 1'b1 || retired !== 32'd1) begin
            n_fail++;
            $display("FAIL irmovq_retire: fetch_en=%b retired=%0d expected 1 1", fetch_en, retired);
        end
        n_checks++;
        if ({cc_zf, cc_sf, cc_of, cnd} !== 4'b1000) begin
            n_fail++;
            $display("FAIL irmovq_cc: zf/sf/of/cnd=%b expected 1000", {cc_zf, cc_sf, cc_of, cnd});
        end
    endtask

    // subq (ZF=1) then je: je sees ZF=1; retired +2 after 12 cycles
    task automatic test_opq_je();
        logic [31:0] base;
        base = retired;
        instr_valid = 1'b1; icode = IOPQ; ifun = 4'h1;
        alu_zf = 1'b1; alu_sf = 1'b0; alu_of = 1'b0;
        tick();                                   // 1: DECODE
        icode = IJXX; ifun = 4'h3;
        tick(); tick();                           // 3: MEMORY of OPq
        alu_zf = 1'b0;
        n_checks++;
        if ({cc_zf, cc_sf, cc_of} !== 3'b100 || cnd !== 1'b0) begin
            n_fail++;
            $display("FAIL opq_cc: cc=%b cnd=%b expected 100 0", {cc_zf, cc_sf, cc_of}, cnd);
        end
        tick(); tick(); tick();                   // 6: FETCH
        n_checks++;
        if (retired !== base + 32'd1) begin
            n_fail++;
            $display("FAIL opq_retire: retired=%0d expected %0d", retired, base + 32'd1);
        end
        tick();                                   // 7: je latched
        instr_valid = 1'b0;
        tick(); tick();                           // 9: MEMORY of je
        n_checks++;
        if (cnd !== 1'b1 || mem_en !== 1'b1) begin
            n_fail++;
            $display("FAIL je_cnd: cnd=%b mem_en=%b expected 1 1", cnd, mem_en);
        end
        tick(); tick(); tick();                   // 12
        n_checks++;
        if (retired !== base + 32'd2 || fetch_en !== 1'b1) begin
            n_fail++;
            $display("FAIL je_retire: retired=%0d fetch_en=%b expected %0d 1",
                     retired, fetch_en, base + 32'd2);
        end
    endtask

    // OPq sets ZF=0 SF=1 OF=0, then a run of jXX/cmovXX over that CC
    task automatic test_cond_table();
        logic [3:0] ic [7];
        logic [3:0] fn [7];
        logic       ex [7];
        logic [31:0] base;
        ic = '{IOPQ, IJXX, IRRMOVQ, IJXX, IJXX, IJXX, IJXX};
        fn = '{4'h1, 4'h2, 4'h6,    4'h0, 4'h7, 4'h1, 4'h4};
        ex = '{1'b0, 1'b1, 1'b0,    1'b1, 1'b0, 1'b1, 1'b1};
        base = retired;
        alu_zf = 1'b0; alu_sf = 1'b1; alu_of = 1'b0;
        instr_valid = 1'b1; icode = ic[0]; ifun = fn[0];
        for (int k = 0; k < 7; k++) begin
            for (int c = 1; c <= 6; c++) begin
                tick();
                if (c == 1) begin
                    if (k < 6) begin
                        icode = ic[k+1]; ifun = fn[k+1];
                    end else begin
                        instr_valid = 1'b0;
                    end
                end
                if (c == 3) begin
                    // disturb ALU flags; non-OPq instructions must not load them
                    alu_zf = 1'b1; alu_sf = 1'b0; alu_of = 1'b1;
                    n_checks++;
                    if (cnd !== ex[k] || {cc_zf, cc_sf, cc_of} !== 3'b010) begin
                        n_fail++;
                        $display("FAIL cond_%0d: icode=%0h ifun=%0h cnd=%b cc=%b expected %b 010",
                                 k, ic[k], fn[k], cnd, {cc_zf, cc_sf, cc_of}, ex[k]);
                    end
                end
            end
        end
        n_checks++;
        if (retired !== base + 32'd7) begin
            n_fail++;
            $display("FAIL cond_retire: retired=%0d expected %0d", retired, base + 32'd7);
        end
    endtask

    // rmmovq with mem_ready low 3 cycles: 4 MEMORY cycles, 9 total
    task automatic test_rmmov_wait();
        int mem_cycles;
        logic [31:0] base;
        base = retired;
        mem_cycles = 0;
        instr_valid = 1'b1; icode = IRMMOVQ; ifun = 4'h0; mem_ready = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) instr_valid = 1'b0;
            if (mem_en) mem_cycles++;
            if (c == 6) mem_ready = 1'b1;
            if (c == 7) mem_ready = 1'b0;
        end
        n_checks++;
        if (mem_cycles != 4) begin
            n_fail++;
            $display("FAIL rmmov_mem_cycles: got %0d expected 4", mem_cycles);
        end
        n_checks++;
        if (retired !== base + 32'd1 || fetch_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rmmov_retire: retired=%0d fetch_en=%b expected %0d 1",
                     retired, fetch_en, base + 32'd1);
        end
    endtask

    // mrmovq hitting a data address fault halts with ADR
    task automatic test_dmem_error();
        logic saw_wb_pc;
        logic [31:0] base;
        base = retired;
        saw_wb_pc = 1'b0;
        instr_valid = 1'b1; icode = IMRMOVQ; ifun = 4'h0;
        mem_ready = 1'b1; dmem_error = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) instr_valid = 1'b0;
            if (c == 4) begin
                start = 1'b1;   // must be ignored in HALT
                n_checks++;
                if (stat !== STAT_ADR || halted !== 1'b1) begin
                    n_fail++;
                    $display("FAIL dmem_halt: stat=%0d halted=%b expected 3 1", stat, halted);
                end
            end
            if (wb_en || pc_en) saw_wb_pc = 1'b1;
        end
        start = 1'b0; mem_ready = 1'b0; dmem_error = 1'b0;
        n_checks++;
        if (saw_wb_pc !== 1'b0 || retired !== base) begin
            n_fail++;
            $display("FAIL dmem_skip: wb_or_pc=%b retired=%0d expected 0 %0d", saw_wb_pc, retired, base);
        end
        n_checks++;
        if (halted !== 1'b1 || fetch_en !== 1'b0 || stat !== STAT_ADR) begin
            n_fail++;
            $display("FAIL dmem_absorb: halted=%b fetch_en=%b stat=%0d expected 1 0 3",
                     halted, fetch_en, stat);
        end
    endtask

    // Fetch-time faults and their priority
    task automatic test_fetch_faults();
        logic [3:0] ic [3];
        logic       ie [3];
        logic [2:0] es [3];
        ic = '{4'hC, IHALT, 4'hC};
        ie = '{1'b0, 1'b0, 1'b1};
        es = '{STAT_INS, STAT_HLT, STAT_ADR};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            go();
            instr_valid = 1'b1; icode = ic[k]; imem_error = ie[k];
            tick();
            instr_valid = 1'b0; imem_error = 1'b0;
            n_checks++;
            if (stat !== es[k] || halted !== 1'b1 || dbg_state !== ST_HALT ||
                {fetch_en, decode_en} !== 2'b00) begin
                n_fail++;
                $display("FAIL fetch_fault_%0d: stat=%0d halted=%b state=%0d expected %0d 1 7",
                         k, stat, halted, dbg_state, es[k]);
            end
        end
    endtask

    // Asynchronous reset during a MEMORY wait, then normal restart
    task automatic test_reset_mid();
        do_reset();
        go();
        instr_valid = 1'b1; icode = IOPQ; ifun = 4'h0;
        alu_zf = 1'b0; alu_sf = 1'b1; alu_of = 1'b1;
        tick();
        icode = IPUSHQ;
        for (int c = 2; c <= 7; c++) tick();      // pushq latched at edge 7
        instr_valid = 1'b0; mem_ready = 1'b0;
        tick(); tick(); tick();                   // edge 10: MEMORY, waiting
        n_checks++;
        if (mem_en !== 1'b1 || retired !== 32'd1 || cc_zf !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pre: mem_en=%b retired=%0d cc_zf=%b expected 1 1 0",
                     mem_en, retired, cc_zf);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_en !== 1'b0 || retired !== 32'd0 || {cc_zf, cc_sf, cc_of} !== 3'b100 ||
            stat !== STAT_AOK || halted !== 1'b0 || cnd !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL mid_async: mem_en=%b retired=%0d cc=%b stat=%0d state=%0d expected 0 0 100 1 0",
                     mem_en, retired, {cc_zf, cc_sf, cc_of}, stat, dbg_state);
        end
        #10 rst_n = 1'b1;
        tick();
        go();
        instr_valid = 1'b1; icode = INOP; ifun = 4'h0;
        tick();
        instr_valid = 1'b0;
        for (int c = 2; c <= 6; c++) tick();
        n_checks++;
        if (retired !== 32'd1 || fetch_en !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_resume: retired=%0d fetch_en=%b expected 1 1", retired, fetch_en);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_irmovq();
        test_opq_je();
        test_cond_table();
        test_rmmov_wait();
        test_dmem_error();
        test_fetch_faults();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_stage_controller.md
# seq_stage_controller

Multi-cycle sequencer for the SEQ Y86-64 core. It steps one instruction at a time through fetch, decode, execute, memory, write-back and PC-update using one-hot stage enables. It owns the architectural condition-code register (ZF/SF/OF), which is loaded from the execute-stage ALU flags, and it derives the branch/cmov condition from that register. It also tracks processor status and halts the core on `halt`, illegal opcodes or memory errors.

## Interface
- No parameters; widths fixed by Y86-64 ISA.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  leave IDLE and begin fetching.
- `instr_valid`  in  1  fetch handshake; `icode`/`ifun`/`imem_error` valid.
- `icode`  in  4  instruction code from fetch.
- `ifun`  in  4  function code from fetch.
- `imem_error`  in  1  instruction address fault.
- `mem_ready`  in  1  data memory handshake; access complete.
- `dmem_error`  in  1  data address fault, qualified by `mem_ready`.
- `alu_zf`, `alu_sf`, `alu_of`  in  1 each  ALU flags from the execute stage.
- `fetch_en`, `decode_en`, `exec_en`, `mem_en`, `wb_en`, `pc_en`  out  1 each  one-hot stage strobes.
- `cc_zf`, `cc_sf`, `cc_of`  out  1 each  condition-code register.
- `cnd`  out  1  registered condition result for jXX/cmovXX.
- `stat`  out  3  status: AOK=1, HLT=2, ADR=3, INS=4.
- `halted`  out  1  high while in HALT.
- `retired`  out  32  count of completed instructions.

## Operation
- States are IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- Each state except IDLE and HALT asserts exactly its own strobe. All strobes are 0 in IDLE and HALT.
- IDLE→FETCH when `start`=1.
- In FETCH:
  - Wait while `instr_valid`=0.
  - When `instr_valid`=1, latch `icode`/`ifun` and apply these checks in priority order:
    1. `imem_error` → stat=ADR, go to HALT.
    2. `icode`>0xB → stat=INS, go to HALT.
    3. `icode`=0 → stat=HLT, go to HALT.
    4. Otherwise go to DECODE.
- DECODE→EXECUTE unconditionally.
- EXECUTE:
  - Register `cnd` from the pre-update CC and the latched ifun.
  - If the latched icode is 2 or 7, `cnd` uses this encoding:
    - ifun 0 → 1
    - ifun 1 → (SF^OF)|ZF
    - ifun 2 → SF^OF
    - ifun 3 → ZF
    - ifun 4 → ~ZF
    - ifun 5 → ~(SF^OF)
    - ifun 6 → ~(SF^OF)&~ZF
    - ifun ≥7 → 0
  - For any other icode, `cnd`=0.
  - If icode=6, load the CC from the `alu_*` flags at the exiting edge. For any other icode the CC holds.
  - Go to MEMORY.
- MEMORY:
  - For icode ∈ {4,5,8,9,A,B}, hold until `mem_ready`=1.
    - If `dmem_error`=1 at that edge → stat=ADR, go to HALT. WRITEBACK and PCUPD are skipped.
    - Otherwise go to WRITEBACK.
  - For other icodes, stay one cycle, ignore `mem_ready`, then go to WRITEBACK.
- WRITEBACK→PCUPD.
- PCUPD→FETCH. `retired` increments by 1 and wraps from 0xFFFFFFFF to 0.
- HALT is absorbing; only reset exits it.
- `start` is ignored outside IDLE.

## Timing
- Reset values:
  - state=IDLE, all strobes 0.
  - cc_zf=1, cc_sf=0, cc_of=0.
  - cnd=0, stat=AOK(1), halted=0, retired=0.
- All outputs are registered or decoded directly from state; there are no combinational input→output paths.
- Latency:
  - A non-memory instruction takes 6 cycles (FETCH through PCUPD) when `instr_valid` is already high.
  - Each cycle `instr_valid` or `mem_ready` is low adds one cycle.
- `halted` rises in the first HALT cycle, together with the final `stat` value.
- When an OPq is followed by a jXX, the jXX sees the CC written by the OPq; the write happens 5 cycles before the jXX's EXECUTE.
- Reset asserted mid-instruction forces IDLE and the reset values at once. No partial retirement is counted.

## Structure
- Package `y86_pkg` holds:
  - icode constants (IHALT…IPOPQ)
  - stat constants (STAT_AOK/HLT/ADR/INS)
  - the 3-bit state enum
  - the `needs_mem(icode)` function
- Sub-module `y86_cond_eval` is combinational: ifun, ZF, SF, OF → cond. The top-level FSM and CC register instantiate it.

## Test plan
- OPq subq with alu_zf=1, alu_sf=0, alu_of=0, then je (icode 7, ifun 3) → cc_zf=1; cnd=1 in the je's MEMORY cycle; retired=2 after 12 cycles.
- rmmovq with `mem_ready` held low for 3 cycles → mem_en high for 4 cycles, total 9 cycles; retired=1.
- mrmovq with `dmem_error`=1 and `mem_ready`=1 → stat=3, halted=1; wb_en and pc_en never assert; retired unchanged.
- icode=0xC at fetch → stat=4, HALT entered straight from FETCH. icode=0 → stat=2. imem_error together with icode=0xC → stat=3.
- Non-OPq (irmovq) with alu_zf=0 → CC keeps its reset value ZF=1.
- rst_n pulsed low during a MEMORY wait → all outputs return to reset values asynchronously; `start` then resumes normal operation.
